// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency-meter count link.
//   SYNC_BYTE  : first byte of every count packet
//   PKT_BYTES  : bytes per packet (sync, counter hi, counter lo, checksum)
//   state_t    : transmit-side packet FSM states
//   pkt_t      : packed packet image, byte0 in the most significant byte
//   make_pkt() : builds a packet (including checksum) from a 16-bit count
//   pkt_byte() : selects packet byte 0..3
package freq_meter_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         PKT_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] sync;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [7:0] chk;
  } pkt_t;

  function automatic pkt_t make_pkt(input logic [15:0] cnt);
    pkt_t p;
    p.sync = SYNC_BYTE;
    p.hi   = cnt[15:8];
    p.lo   = cnt[7:0];
    p.chk  = SYNC_BYTE ^ cnt[15:8] ^ cnt[7:0];
    return p;
  endfunction

  function automatic logic [7:0] pkt_byte(input pkt_t p, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = p.sync;
      2'd1:    b = p.hi;
      2'd2:    b = p.lo;
      default: b = p.chk;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter.
//   clk   : system clock
//   rst   : synchronous active-high reset; line returns to idle (1)
//   start : load data and begin the start bit in the next cycle;
//           accepted while idle or in the done cycle (gapless chaining)
//   data  : byte to send, LSB first
//   tx    : serial line, registered, idles high
//   done  : high in the last cycle of the stop bit
// Every bit lasts exactly CLKS_PER_BIT cycles; the baud counter restarts at
// each bit boundary so there is no accumulated drift.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             r_active;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_bit;     // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]       r_data;
  logic             r_tx;
  logic             w_bit_end;

  assign w_bit_end = r_active && (r_cnt == CNT_LAST);
  assign done      = w_bit_end && (r_bit == 4'd9);
  assign tx        = r_tx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_data   <= '0;
      r_tx     <= 1'b1;
    end else if (start) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_data   <= data;
      r_tx     <= 1'b0;
    end else if (w_bit_end) begin
      r_cnt <= '0;
      if (r_bit == 4'd9) begin
        r_active <= 1'b0;
        r_bit    <= '0;
        r_tx     <= 1'b1;
      end else begin
        r_bit <= r_bit + 4'd1;
        // Leaving bit r_bit: next is data bit r_bit (0..7) or the stop bit.
        r_tx  <= (r_bit == 4'd8) ? 1'b1 : r_data[r_bit[2:0]];
      end
    end else if (r_active) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/count_packet_tx.sv
// Transmit side of the frequency-meter count link.
//   clk         : system clock
//   rst         : synchronous active-high reset
//   send_packet : request strobe, each high cycle is one request
//   counter     : 16-bit count, sampled only on accepted request cycles
//   tx          : UART 8N1 line, idles high
//   busy        : high while a packet is being shifted out
//   pending     : high while a captured request waits for the line
//   drop        : one-cycle pulse when a pending request is overwritten
// Packet: A5, counter[15:8], counter[7:0], A5^hi^lo, sent back-to-back.
module count_packet_tx
  import freq_meter_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send_packet,
  input  logic [15:0] counter,
  output logic        tx,
  output logic        busy,
  output logic        pending,
  output logic        drop
);

  // Must be >= 2 for the byte transmitter's done/start handshake.
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam logic [1:0] LAST_IDX = 2'(PKT_BYTES - 1);

  state_t      r_state;
  logic [1:0]  r_byte_idx;
  pkt_t        r_pkt;
  logic [15:0] r_pend_val;
  logic        r_pending;
  logic        r_busy;
  logic        r_drop;

  logic        w_done;
  logic        w_last_done;
  logic        w_launch;
  logic        w_next_byte;
  logic        w_start;
  logic [15:0] w_launch_val;
  logic [7:0]  w_data;

  assign w_last_done = w_done && (r_state == ST_SEND) && (r_byte_idx == LAST_IDX);
  assign w_next_byte = w_done && (r_state == ST_SEND) && (r_byte_idx != LAST_IDX);

  // LOAD is not a resting state: loading the packet and starting byte0 happen
  // in the cycle that leaves IDLE or finishes byte3, so a new packet costs no
  // extra cycle. A request arriving in the final cycle is chained directly
  // and wins over an older pending value.
  assign w_launch = ((r_state == ST_IDLE) && send_packet) ||
                    (w_last_done && (send_packet || r_pending));
  assign w_launch_val = send_packet ? counter : r_pend_val;
  assign w_start = w_launch || w_next_byte;
  assign w_data  = w_launch ? SYNC_BYTE : pkt_byte(r_pkt, r_byte_idx + 2'd1);

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart (
    .clk   (clk),
    .rst   (rst),
    .start (w_start),
    .data  (w_data),
    .tx    (tx),
    .done  (w_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_byte_idx <= '0;
      r_pkt      <= '0;
      r_pend_val <= '0;
      r_pending  <= 1'b0;
      r_busy     <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (send_packet) begin
            r_state    <= ST_SEND;
            r_pkt      <= make_pkt(counter);
            r_byte_idx <= '0;
            r_busy     <= 1'b1;
          end
        end
        ST_SEND: begin
          if (w_last_done) begin
            r_byte_idx <= '0;
            if (w_launch) begin
              r_pkt     <= make_pkt(w_launch_val);
              r_pending <= 1'b0;
              r_drop    <= send_packet && r_pending;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            if (w_next_byte) begin
              r_byte_idx <= r_byte_idx + 2'd1;
            end
            if (send_packet) begin
              r_pend_val <= counter;
              r_pending  <= 1'b1;
              r_drop     <= r_pending;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign pending = r_pending;
  assign drop    = r_drop;

endmodule

// File: tb/tb_count_packet_tx.sv
// Directed bench for count_packet_tx with CLKS_PER_BIT = 4.
module tb_count_packet_tx;

  localparam int CPB     = 4;
  localparam int PKT_CYC = 40 * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic        send_packet;
  logic [15:0] counter;
  logic        tx;
  logic        busy;
  logic        pending;
  logic        drop;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  exp_q[$];
  int          inj_k[$];
  logic [15:0] inj_v[$];

  count_packet_tx #(
    .CLK_FREQ  (40),
    .BAUD_RATE (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .send_packet (send_packet),
    .counter     (counter),
    .tx          (tx),
    .busy        (busy),
    .pending     (pending),
    .drop        (drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] v);
    counter     = v;
    send_packet = 1'b1;
    tick();
    send_packet = 1'b0;
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      check(tag, {28'd0, tx, busy, pending, drop}, 32'b1000);
      tick();
    end
  endtask

  // Called in the first cycle of a packet train. Walks every cycle, compares
  // tx against the framed expected bytes in exp_q, busy, and a small model of
  // pending/drop; fires the requests listed in inj_k/inj_v at those offsets.
  task automatic expect_frames(input string tag);
    int         total;
    int         b;
    int         i;
    logic [7:0] cur;
    logic       exp_bit;
    logic       inj;
    logic       last;
    logic       m_pend;
    logic       m_drop;
    logic       nxt_pend;
    logic       nxt_drop;
    total  = exp_q.size() * 10 * CPB;
    m_pend = 1'b0;
    m_drop = 1'b0;
    for (int k = 0; k < total; k++) begin
      b   = k / (10 * CPB);
      i   = (k % (10 * CPB)) / CPB;
      cur = exp_q[b];
      if (i == 0)      exp_bit = 1'b0;
      else if (i == 9) exp_bit = 1'b1;
      else             exp_bit = cur[i-1];
      check({tag, "_tx"},      {31'd0, tx},      {31'd0, exp_bit});
      check({tag, "_busy"},    {31'd0, busy},    32'd1);
      check({tag, "_pending"}, {31'd0, pending}, {31'd0, m_pend});
      check({tag, "_drop"},    {31'd0, drop},    {31'd0, m_drop});
      inj = 1'b0;
      for (int j = 0; j < inj_k.size(); j++) begin
        if (inj_k[j] == k) begin
          inj     = 1'b1;
          counter = inj_v[j];
        end
      end
      send_packet = inj;
      last     = ((k + 1) % PKT_CYC) == 0;
      nxt_drop = inj && m_pend;
      nxt_pend = last ? 1'b0 : (inj || m_pend);
      tick();
      send_packet = 1'b0;
      m_pend = nxt_pend;
      m_drop = nxt_drop;
    end
    check({tag, "_end_tx"},      {31'd0, tx},      32'd1);
    check({tag, "_end_busy"},    {31'd0, busy},    32'd0);
    check({tag, "_end_pending"}, {31'd0, pending}, 32'd0);
    check({tag, "_end_drop"},    {31'd0, drop},    {31'd0, m_drop});
    exp_q.delete();
    inj_k.delete();
    inj_v.delete();
  endtask

  initial begin
    rst         = 1'b1;
    send_packet = 1'b0;
    counter     = 16'h0000;

    // Reset and idle
    tick();
    check("reset_state", {28'd0, tx, busy, pending, drop}, 32'b1000);
    tick();
    rst = 1'b0;
    check_idle("idle", 100);

    // Single packet 0x1234
    check("pre_busy", {31'd0, busy}, 32'd0);
    send(16'h1234);
    exp_q = '{8'hA5, 8'h12, 8'h34, 8'h83};
    expect_frames("pkt1234");
    check_idle("after1234", 10);

    // Pending overwrite: 0x00FF then 0xBEEF during packet 0x0001
    send(16'h0001);
    exp_q = '{8'hA5, 8'h00, 8'h01, 8'hA4, 8'hA5, 8'hBE, 8'hEF, 8'hF4};
    inj_k = '{20, 60};
    inj_v = '{16'h00FF, 16'hBEEF};
    expect_frames("overwrite");
    check_idle("after_ovw", 10);

    // Request in the final cycle of a packet chains without gap
    send(16'h0102);
    exp_q = '{8'hA5, 8'h01, 8'h02, 8'hA6, 8'hA5, 8'h03, 8'h04, 8'hA2};
    inj_k = '{PKT_CYC - 1};
    inj_v = '{16'h0304};
    expect_frames("lastcycle");
    check_idle("after_last", 10);

    // All ones then all zeros
    send(16'hFFFF);
    exp_q = '{8'hA5, 8'hFF, 8'hFF, 8'hA5};
    expect_frames("pktFFFF");
    check_idle("gapFFFF", 5);
    send(16'h0000);
    exp_q = '{8'hA5, 8'h00, 8'h00, 8'hA5};
    expect_frames("pkt0000");
    check_idle("after0000", 5);

    // Reset in the middle of byte2, with a request pending
    send(16'h1234);
    for (int c = 0; c < 10; c++) tick();
    send(16'h7777);
    check("mid_pending", {31'd0, pending}, 32'd1);
    for (int c = 0; c < 80; c++) tick();
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid", {28'd0, tx, busy, pending, drop}, 32'b1000);
    check_idle("after_rst_mid", 200);
    send(16'h5A5A);
    exp_q = '{8'hA5, 8'h5A, 8'h5A, 8'hA5};
    expect_frames("pkt5A5A");

    // Reset and request in the same cycle: reset wins
    rst         = 1'b1;
    send_packet = 1'b1;
    counter     = 16'hCAFE;
    tick();
    rst         = 1'b0;
    send_packet = 1'b0;
    check_idle("rst_and_req", 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
